// File: rtl/lapido_pkg.sv
// Shared Lapido definitions: fetch FSM encoding, instruction field positions and fetch defaults.
package lapido_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned       DEFAULT_PC_STEP  = 4;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_MSB  = 20;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_MSB  = 15;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] pc_advance(input logic [ADDR_W-1:0] pc,
                                                   input int unsigned step);
    return pc + ADDR_W'(step);
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry {instr, pc4} buffer catching a word acked while decode is stalled.
module fetch_hold_buffer
  import lapido_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc4,
  output logic               full,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc4
);

  logic               full_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc4_q;

  // Clear wins over load so a branch in the same cycle drops the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else if (clear) begin
      full_q <= 1'b0;
    end else if (load) begin
      full_q  <= 1'b1;
      instr_q <= load_instr;
      pc4_q   <= load_pc4;
    end
  end

  assign full  = full_q;
  assign instr = instr_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Lapido instruction-fetch stage: PC, imem handshake, hold buffer and IF/ID register.
// Optional bubble counter enabled by defining FETCH_BUBBLE_COUNT_EN.
module fetch_stage
  import lapido_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  output logic                if_id_valid,
  output logic [ADDR_W-1:0]   if_id_pc4,
  output logic [INSTR_W-1:0]  if_id_instr,
  output logic [5:0]          if_id_opcode,
  output logic [4:0]          if_id_rs,
  output logic [4:0]          if_id_rt,
  output logic [4:0]          if_id_rd,
  output logic [IMM_W-1:0]    if_id_imm,
  output logic [31:0]         perf_bubbles
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;

  logic               hb_load, hb_clear, hb_full;
  logic [INSTR_W-1:0] hb_instr;
  logic [ADDR_W-1:0]  hb_pc4;

  logic               fire;
  logic [ADDR_W-1:0]  pc_next_seq;

  assign imem_req    = (state_q == FS_REQ);
  assign imem_addr   = pc_q;
  assign fire        = imem_req & imem_ack;
  assign pc_next_seq = pc_advance(pc_q, PC_STEP);

  fetch_hold_buffer u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (hb_load),
    .clear      (hb_clear),
    .load_instr (imem_rdata),
    .load_pc4   (pc_next_seq),
    .full       (hb_full),
    .instr      (hb_instr),
    .pc4        (hb_pc4)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    hb_load  = 1'b0;
    hb_clear = 1'b0;

    unique case (state_q)
      FS_IDLE: begin
        state_d = FS_REQ;
      end
      FS_REQ: begin
        if (fire) begin
          pc_d = pc_next_seq;
          if (stall) begin
            hb_load = 1'b1;
            state_d = FS_HOLD;
          end else begin
            instr_d = imem_rdata;
            pc4_d   = pc_next_seq;
            valid_d = 1'b1;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      FS_HOLD: begin
        if (!stall && hb_full) begin
          instr_d  = hb_instr;
          pc4_d    = hb_pc4;
          valid_d  = 1'b1;
          hb_clear = 1'b1;
          state_d  = FS_REQ;
        end
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase

    // Redirect overrides stall, ack and state; any word acked this cycle is dropped.
    if (branch_taken) begin
      pc_d     = branch_target;
      valid_d  = 1'b0;
      hb_load  = 1'b0;
      hb_clear = 1'b1;
      state_d  = FS_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign if_id_valid  = valid_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_instr  = instr_q;
  assign if_id_opcode = instr_q[OPC_MSB:OPC_LSB];
  assign if_id_rs     = instr_q[RS_MSB:RS_LSB];
  assign if_id_rt     = instr_q[RT_MSB:RT_LSB];
  assign if_id_rd     = instr_q[RD_MSB:RD_LSB];
  assign if_id_imm    = instr_q[IMM_MSB:IMM_LSB];

`ifdef FETCH_BUBBLE_COUNT_EN
  logic [31:0] bubbles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubbles_q <= '0;
    end else if (!valid_q && (bubbles_q != 32'hFFFF_FFFF)) begin
      bubbles_q <= bubbles_q + 32'd1;
    end
  end

  assign perf_bubbles = bubbles_q;
`else
  assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, decode slices, stall/hold, branch, bubbles, wrap, reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_id_valid;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic [5:0]  if_id_opcode;
  logic [4:0]  if_id_rs;
  logic [4:0]  if_id_rt;
  logic [4:0]  if_id_rd;
  logic [15:0] if_id_imm;
  logic [31:0] perf_bubbles;

  logic        ovr_en;
  logic [31:0] ovr_word;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_BUBBLE_COUNT_EN
  localparam int unsigned BubScale = 1;
`else
  localparam int unsigned BubScale = 0;
`endif

  always #5 clk = ~clk;

  assign imem_rdata = ovr_en ? ovr_word : (imem_addr ^ 32'hA5A5_0000);

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (if_id_valid),
    .if_id_pc4     (if_id_pc4),
    .if_id_instr   (if_id_instr),
    .if_id_opcode  (if_id_opcode),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .if_id_rd      (if_id_rd),
    .if_id_imm     (if_id_imm),
    .perf_bubbles  (perf_bubbles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    imem_ack      = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    ovr_en        = 1'b0;
    ovr_word      = 32'h0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    tick();
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_bub", perf_bubbles, 32'h0);
    rst = 1'b0;

    tick();  // IDLE -> REQ
    chk("req_up", 32'(imem_req), 32'd1);
    chk("addr0", imem_addr, 32'h0);
    chk("valid_lo1", 32'(if_id_valid), 32'd0);

    tick();  // word@0 latched
    chk("valid_up", 32'(if_id_valid), 32'd1);
    chk("instr0", if_id_instr, 32'hA5A5_0000);
    chk("pc4_0", if_id_pc4, 32'h4);
    chk("imm0", 32'(if_id_imm), 32'h0000);
    chk("addr4", imem_addr, 32'h4);
    chk("bub_exit", perf_bubbles, 32'(2 * BubScale));

    tick();  // word@4 latched
    chk("instr4", if_id_instr, 32'hA5A5_0004);
    chk("pc4_4", if_id_pc4, 32'h8);
    chk("imm4", 32'(if_id_imm), 32'h0004);
    chk("addr8", imem_addr, 32'h8);

    // Stall coincides with ack at pc=8: word goes to hold buffer.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_instr", if_id_instr, 32'hA5A5_0004);
      chk("hold_pc4", if_id_pc4, 32'h8);
      chk("hold_valid", 32'(if_id_valid), 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("rel_instr", if_id_instr, 32'hA5A5_0008);
    chk("rel_pc4", if_id_pc4, 32'hC);
    chk("rel_valid", 32'(if_id_valid), 32'd1);
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'hC);

    // Field decode of a fixed word.
    ovr_en   = 1'b1;
    ovr_word = 32'h2008_FFFF;
    tick();
    ovr_en = 1'b0;
    chk("dec_opc", 32'(if_id_opcode), 32'h08);
    chk("dec_rs", 32'(if_id_rs), 32'h0);
    chk("dec_rt", 32'(if_id_rt), 32'h8);
    chk("dec_rd", 32'(if_id_rd), 32'h1F);
    chk("dec_imm", 32'(if_id_imm), 32'hFFFF);
    chk("dec_pc4", if_id_pc4, 32'h10);
    chk("addr10", imem_addr, 32'h10);

    // Branch together with stall and ack.
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    stall         = 1'b1;
    tick();
    branch_taken = 1'b0;
    stall        = 1'b0;
    chk("br_valid", 32'(if_id_valid), 32'd0);
    chk("br_req", 32'(imem_req), 32'd1);
    chk("br_addr", imem_addr, 32'h100);
    chk("br_hb_empty", 32'(dut.hb_full), 32'd0);
    tick();
    chk("br_valid2", 32'(if_id_valid), 32'd1);
    chk("br_instr", if_id_instr, 32'hA5A5_0100);
    chk("br_pc4", if_id_pc4, 32'h104);
    chk("bub_br", perf_bubbles, 32'(3 * BubScale));

    // Four cycles without ack.
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bub_valid", 32'(if_id_valid), 32'd0);
      chk("bub_addr", imem_addr, 32'h104);
      chk("bub_req", 32'(imem_req), 32'd1);
    end
    imem_ack = 1'b1;
    tick();
    chk("bub_resume", if_id_instr, 32'hA5A5_0104);
    chk("bub_cnt", perf_bubbles, 32'(7 * BubScale));

    // PC wrap.
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_next", imem_addr, 32'h0);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_instr", if_id_instr, 32'h5A5A_FFFC);
    chk("wrap_bub", perf_bubbles, 32'(8 * BubScale));
    tick();
    chk("wrap_addr4", imem_addr, 32'h4);

    // Reset during REQ beats a simultaneous branch.
    rst           = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    tick();
    rst          = 1'b0;
    branch_taken = 1'b0;
    chk("mrst_req", 32'(imem_req), 32'd0);
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_valid", 32'(if_id_valid), 32'd0);
    chk("mrst_bub", perf_bubbles, 32'h0);
    tick();
    chk("mrst_req2", 32'(imem_req), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
